stream_fifo: RTL and testbench

Synchronous first-word-fall-through FIFO with valid/ready handshakes on both sides. Storage is a `dual_port_ram` instance (synchronous write, combinational read, contents not reset). This block owns:
- write and read pointers,
- full/empty generation,
- flush,
- an optional occupancy interface.

It sits directly upstream of the RAM, generating all of its address and enable inputs, and downstream of any producer needing elastic buffering.

---
 rtl/stream_fifo_pkg.sv | 15 +
 rtl/dual_port_ram.sv | 23 ++
 rtl/stream_fifo.sv | 81 ++++++++
 tb/tb_stream_fifo.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/stream_fifo_pkg.sv
// Shared definitions for stream_fifo: default geometry, pointer width helper, level type.
package stream_fifo_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 3;
  localparam int DEF_DEPTH      = 2 ** DEF_ADDR_WIDTH;

  // One extra bit distinguishes full from empty when the low bits match.
  function automatic int ptr_width(input int aw);
    return aw + 1;
  endfunction

  typedef logic [DEF_ADDR_WIDTH:0] level_t;

endpackage

// File: rtl/dual_port_ram.sv
// Simple dual-port storage: synchronous write, combinational read, contents not reset.
module dual_port_ram #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 3
)(
  input  logic                  clk,
  input  logic                  write_en_i,
  input  logic [ADDR_WIDTH-1:0] write_addr_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  read_en_i,
  input  logic [ADDR_WIDTH-1:0] read_addr_i,
  output logic [DATA_WIDTH-1:0] data_o
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (write_en_i) mem[write_addr_i] <= data_i;
  end

  assign data_o = read_en_i ? mem[read_addr_i] : '0;

endmodule

// File: rtl/stream_fifo.sv
// First-word-fall-through FIFO with valid/ready on both sides over a dual_port_ram.
// Define STREAM_FIFO_LEVEL_EN to add the level_o / almost_full_o occupancy outputs.
module stream_fifo
  import stream_fifo_pkg::*;
#(
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int AFULL_THRESH = (2 ** ADDR_WIDTH) - 2
)(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush_i,
  input  logic [DATA_WIDTH-1:0] in_data_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  output logic [DATA_WIDTH-1:0] out_data_o,
  output logic                  out_valid_o,
  input  logic                  out_ready_i
`ifdef STREAM_FIFO_LEVEL_EN
  ,
  output logic [ADDR_WIDTH:0]   level_o,
  output logic                  almost_full_o
`endif
);

  localparam int PW = ptr_width(ADDR_WIDTH);

  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic                  empty, full, push, pop;
  logic [DATA_WIDTH-1:0] ram_rdata;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]) &&
                 (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]);

  // Ready/valid come only from registered pointers: no pass-through when full.
  assign in_ready_o  = !full;
  assign out_valid_o = !empty;
  assign push        = in_valid_i & in_ready_o;
  assign pop         = out_valid_o & out_ready_i;
  assign out_data_o  = empty ? '0 : ram_rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  dual_port_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .clk          (clk),
    .write_en_i   (push),
    .write_addr_i (wr_ptr[ADDR_WIDTH-1:0]),
    .data_i       (in_data_i),
    .read_en_i    (1'b1),
    .read_addr_i  (rd_ptr[ADDR_WIDTH-1:0]),
    .data_o       (ram_rdata)
  );

`ifdef STREAM_FIFO_LEVEL_EN
  localparam logic [PW-1:0] AFULL_LVL = PW'(AFULL_THRESH);
  logic [PW-1:0] level;

  assign level         = wr_ptr - rd_ptr;
  assign level_o       = level;
  assign almost_full_o = (level >= AFULL_LVL);
`else
  logic unused_afull_thresh;
  assign unused_afull_thresh = (AFULL_THRESH != 0);
`endif

endmodule

// File: tb/tb_stream_fifo.sv
// Self-checking bench for stream_fifo: queue reference model plus directed and random traffic.
module tb_stream_fifo;

  localparam int DW    = 32;
  localparam int AW    = 3;
  localparam int DEPTH = 8;
  localparam int AFT   = 6;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready = 1'b0;
`ifdef STREAM_FIFO_LEVEL_EN
  logic [AW:0]   level;
  logic          afull;
`endif

  int tests = 0;
  int fails = 0;

  logic [DW-1:0] mq[$];

  stream_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AFULL_THRESH(AFT)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush_i     (flush),
    .in_data_i   (in_data),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .out_data_o  (out_data),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready)
`ifdef STREAM_FIFO_LEVEL_EN
    ,
    .level_o       (level),
    .almost_full_o (afull)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_lvl(input int exp);
`ifdef STREAM_FIFO_LEVEL_EN
    check("level", 32'(level), 32'(exp));
    check("afull", 32'(afull), 32'(exp >= AFT));
`endif
  endtask

  // Inputs are applied 1 time unit after an edge, held through the next edge.
  task automatic cyc(input logic v, input logic [DW-1:0] d, input logic r, input logic f);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    flush     = f;
    @(posedge clk);
    #1;
  endtask

  // Reference model: an ordered queue of at most DEPTH words.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) mq.delete();
    else if (flush) mq.delete();
    else begin
      automatic bit pu = in_valid && (mq.size() < DEPTH);
      automatic bit po = out_ready && (mq.size() > 0);
      if (po) void'(mq.pop_front());
      if (pu) mq.push_back(in_data);
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      automatic int n = mq.size();
      check("cyc_valid", 32'(out_valid), 32'(n != 0));
      check("cyc_ready", 32'(in_ready), 32'(n < DEPTH));
      check("cyc_data", out_data, (n != 0) ? mq[0] : '0);
`ifdef STREAM_FIFO_LEVEL_EN
      check("cyc_level", 32'(level), 32'(n));
      check("cyc_afull", 32'(afull), 32'(n >= AFT));
`endif
    end
  end

  initial begin
    int wi, ri, n;
    logic v, r;

    // Reset state
    #3;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_ready", 32'(in_ready), 32'd1);
    check("rst_data", out_data, 32'd0);
    check_lvl(0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Fill to full with consumer stalled
    for (int i = 1; i <= 8; i++) begin
      cyc(1'b1, DW'(i), 1'b0, 1'b0);
      check("fill_ready", 32'(in_ready), 32'(i < 8));
      check("fill_head", out_data, 32'd1);
      check_lvl(i);
    end
    cyc(1'b1, 32'h9, 1'b0, 1'b0);
    check("overfill_ready", 32'(in_ready), 32'd0);
    check_lvl(8);

    // Full with simultaneous push and pop: pop wins, push rejected
    check("simul_head", out_data, 32'd1);
    cyc(1'b1, 32'h99, 1'b1, 1'b0);
    check("simul_ready", 32'(in_ready), 32'd1);
    check("simul_head2", out_data, 32'd2);
    check_lvl(7);

    // Drain remaining words in order
    for (int i = 2; i <= 8; i++) begin
      check("drain_data", out_data, DW'(i));
      cyc(1'b0, '0, 1'b1, 1'b0);
    end
    check("drain_valid", 32'(out_valid), 32'd0);
    check("drain_data0", out_data, 32'd0);
    check_lvl(0);

    // Empty latency: visible only after the write edge
    in_valid = 1'b1; in_data = 32'hDEADBEEF; out_ready = 1'b0;
    #2;
    check("lat_pre_valid", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    check("lat_valid", 32'(out_valid), 32'd1);
    check("lat_data", out_data, 32'hDEADBEEF);
    cyc(1'b0, '0, 1'b1, 1'b0);
    check("lat_empty", 32'(out_valid), 32'd0);

    // Flush with concurrent push
    for (int i = 0; i < 4; i++) cyc(1'b1, DW'(32'h10 + i), 1'b0, 1'b0);
    check_lvl(4);
    check("pre_flush_head", out_data, 32'h10);
    cyc(1'b1, 32'hA5, 1'b0, 1'b1);
    check("flush_valid", 32'(out_valid), 32'd0);
    check("flush_ready", 32'(in_ready), 32'd1);
    check_lvl(0);
    cyc(1'b1, 32'h5A, 1'b0, 1'b0);
    check("post_flush_data", out_data, 32'h5A);
    cyc(1'b0, '0, 1'b1, 1'b0);
    check("post_flush_empty", 32'(out_valid), 32'd0);

    // Wrap: 20 words with random gaps on both sides
    wi = 0; ri = 0; n = 0;
    while (ri < 20 && n < 600) begin
      v = (wi < 20) && ($urandom_range(0, 1) == 1);
      r = ($urandom_range(0, 1) == 1);
      if (r && mq.size() > 0) begin
        check("wrap_seq", out_data, DW'(ri));
        ri++;
      end
      if (v && mq.size() < DEPTH) begin
        cyc(1'b1, DW'(wi), r, 1'b0);
        wi++;
      end else begin
        cyc(1'b0, '0, r, 1'b0);
      end
      n++;
    end
    check("wrap_done", 32'(ri), 32'd20);

    // Random traffic, producer-heavy then consumer-heavy, rare flushes
    for (int i = 0; i < 800; i++) begin
      v = (i < 400) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      r = (i < 400) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      cyc(v, DW'($urandom), r, ($urandom_range(0, 80) == 0));
    end
    n = 0;
    while (mq.size() > 0 && n < 20) begin
      cyc(1'b0, '0, 1'b1, 1'b0);
      n++;
    end
    check("rand_drained", 32'(out_valid), 32'd0);

    // Asynchronous reset with 5 words stored
    for (int i = 0; i < 5; i++) cyc(1'b1, DW'(32'h30 + i), 1'b0, 1'b0);
    check_lvl(5);
    check("pre_rst_valid", 32'(out_valid), 32'd1);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(out_valid), 32'd0);
    check("arst_ready", 32'(in_ready), 32'd1);
    check("arst_data", out_data, 32'd0);
    check_lvl(0);
    cyc(1'b0, '0, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b0);
    rst_n = 1'b1;
    cyc(1'b1, 32'h77, 1'b0, 1'b0);
    cyc(1'b1, 32'h78, 1'b0, 1'b0);
    check("post_rst_first", out_data, 32'h77);
    cyc(1'b0, '0, 1'b1, 1'b0);
    check("post_rst_second", out_data, 32'h78);
    cyc(1'b0, '0, 1'b1, 1'b0);
    check("post_rst_empty", 32'(out_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
